sdram_responder: RTL and testbench
==================================

SDRAM_RESPONDER -- requirements
Module: sdram_responder

Interface
REQ-001 SHALL have parameter T_INIT, default 10000, power-up wait in cycles before the first command.
REQ-002 SHALL have parameter T_RCD, default 2, cycles from ACTIVE to READ/WRITE.
REQ-003 SHALL have parameter T_RP, default 2, precharge recovery in cycles.
REQ-004 SHALL have parameter T_RC, default 7, refresh/activate cycle time in cycles.
REQ-005 SHALL have parameter CAS_LATENCY, default 2; only 2 or 3 are legal.
REQ-006 SHALL have parameter REFRESH_INTERVAL, default 780, cycles between refreshes.
REQ-007 memClk  in  1  sole clock; all logic on the rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 address  in  24  request address: [23:22] bank, [21:9] row, [8:0] column.
REQ-010 write  in  1  write request strobe.
REQ-011 read  in  1  read request strobe.
REQ-012 dataIn  in  16  write data, sampled with write.
REQ-013 busy  out  1  responder cannot accept a request.
REQ-014 dataOut  out  16  read data.
REQ-015 readReady  out  1  one-cycle pulse; dataOut valid.
REQ-016 sdramCke, sdramCsN, sdramRasN, sdramCasN, sdramWeN  out  1 each  SDRAM control lines.
REQ-017 sdramBa  out  2 and sdramAddr  out  13  SDRAM bank and address lines.
REQ-018 sdramDqm  out  2  byte masks.
REQ-019 sdramDqOut  out  16, sdramDqOe  out  1, sdramDqIn  in  16  split data bus.

Function
REQ-020 All SDRAM outputs SHALL be registered; a NOP SHALL be CS_N=0, RAS_N=1, CAS_N=1, WE_N=1.
REQ-021 The FSM SHALL be: INIT_WAIT -> INIT_PRE -> INIT_REF1 -> INIT_REF2 -> INIT_MRS -> IDLE; IDLE -> REFRESH | ACTIVATE; ACTIVATE -> RDWR -> CAS_WAIT (reads only) -> RECOVER -> IDLE; REFRESH -> RECOVER -> IDLE.
REQ-022 Initialisation sequence:
  - INIT_WAIT holds NOP for T_INIT cycles with Cke=1 and Dqm=11.
  - INIT_PRE issues PRECHARGE with Addr[10]=1, then waits T_RP cycles.
  - INIT_REF1 and INIT_REF2 each issue AUTO REFRESH, then wait T_RC cycles.
  - INIT_MRS loads mode register Addr = {3'b0, 1'b0, 2'b00, CAS_LATENCY[2:0], 1'b0, 3'b000} (burst length 1, sequential), then waits 2 cycles.
REQ-023 busy SHALL be combinational: 1 when state != IDLE, when refreshPending=1, or when read or write is high.
REQ-024 A request SHALL be accepted at the rising edge where state=IDLE, refreshPending=0, and read or write is 1; address and dataIn are latched at that edge.
REQ-025 If read and write are both 1 at acceptance, the write SHALL be performed and the read discarded.
REQ-026 Strobes arriving outside the acceptance condition SHALL be ignored; nothing is queued.
REQ-027 ACTIVE SHALL be issued in the cycle after acceptance, using latched bank and row.
REQ-028 READ/WRITE SHALL be issued T_RCD cycles after ACTIVE, with Addr={2'b0, Addr[10]=1 (auto-precharge), column[9:0] zero-extended from [8:0]}.
REQ-029 Write cycle: sdramDqOe=1 and sdramDqOut=latched data for exactly that one cycle; Dqm=00.
REQ-030 Read data: sdramDqIn SHALL be registered CAS_LATENCY cycles after the READ command into dataOut, with readReady=1 for that single cycle; read latency from acceptance edge = 2 + T_RCD + CAS_LATENCY cycles.
REQ-031 RECOVER SHALL wait until T_RC cycles have elapsed since ACTIVE/REFRESH, and at least T_RP cycles, before IDLE.
REQ-032 The refresh counter SHALL count down from REFRESH_INTERVAL-1 and set refreshPending at 0, then reload.
REQ-033 In IDLE, refreshPending SHALL take priority over a request; REFRESH clears it.
REQ-034 refreshPending set during an access SHALL be served immediately after RECOVER, with no request accepted in between.
REQ-035 The counter SHALL keep running during init, but pending is cleared on entering IDLE from INIT_MRS.
REQ-036 dataOut SHALL hold its last read value until the next readReady.

Reset
REQ-037 While reset=1: state=INIT_WAIT, busy=1, readReady=0, dataOut=0, Cke=0, NOP, Ba=0, Addr=0, Dqm=11, DqOe=0, DqOut=0, refreshPending=0, counters reloaded.
REQ-038 Reset asserted mid-access SHALL abort the access with no readReady, then rerun the full init sequence.

Verification
REQ-039 Release reset -> exact PRE, REF, REF, MRS order with Addr=0x020 (CL2); busy falls after INIT_MRS+2 cycles.
REQ-040 write=1, address=0x400203, dataIn=0xBEEF at idle -> ACTIVE with Ba=1, row=1; T_RCD later WRITE with col=3, Addr[10]=1, DqOut=0xBEEF, DqOe=1.
REQ-041 Read of the same address with sdramDqIn model returning 0xBEEF -> readReady pulse 6 cycles after acceptance (defaults), dataOut=0xBEEF.
REQ-042 read=1 and write=1 together -> only a WRITE command is issued and no readReady is produced.
REQ-043 refreshPending and a request in the same IDLE cycle -> REFRESH first, request ignored, busy=1 throughout; a re-issued request is accepted after RECOVER.
REQ-044 Reset pulse between READ and data return -> no readReady, outputs at reset values, init restarts.

Source files
------------

// File: rtl/sdram_responder_if.sv
// Host request/response and SDRAM pin bundle for the SDRAM responder.
interface sdram_responder_if;
    logic [23:0] address;
    logic        write;
    logic        read;
    logic [15:0] dataIn;
    logic        busy;
    logic [15:0] dataOut;
    logic        readReady;
    logic        sdramCke;
    logic        sdramCsN;
    logic        sdramRasN;
    logic        sdramCasN;
    logic        sdramWeN;
    logic [1:0]  sdramBa;
    logic [12:0] sdramAddr;
    logic [1:0]  sdramDqm;
    logic [15:0] sdramDqOut;
    logic        sdramDqOe;
    logic [15:0] sdramDqIn;

    // Responder side: takes host requests and drives the SDRAM pins.
    modport slave (
        input  address, write, read, dataIn, sdramDqIn,
        output busy, dataOut, readReady,
        output sdramCke, sdramCsN, sdramRasN, sdramCasN, sdramWeN,
        output sdramBa, sdramAddr, sdramDqm, sdramDqOut, sdramDqOe
    );

    // Host/memory-model side.
    modport master (
        output address, write, read, dataIn, sdramDqIn,
        input  busy, dataOut, readReady,
        input  sdramCke, sdramCsN, sdramRasN, sdramCasN, sdramWeN,
        input  sdramBa, sdramAddr, sdramDqm, sdramDqOut, sdramDqOe
    );
endinterface

// File: rtl/sdram_responder.sv
// Single-word SDRAM controller: power-up init, periodic auto refresh,
// and one auto-precharged read or write per accepted request.
module sdram_responder #(
    parameter int unsigned T_INIT           = 10000,
    parameter int unsigned T_RCD            = 2,
    parameter int unsigned T_RP             = 2,
    parameter int unsigned T_RC             = 7,
    parameter int unsigned CAS_LATENCY      = 2,   // 2 or 3 only
    parameter int unsigned REFRESH_INTERVAL = 780
) (
    input  logic             memClk,
    input  logic             reset,
    sdram_responder_if.slave bus
);
    localparam int unsigned WAIT_W = $clog2(T_INIT + T_RC + T_RP + T_RCD + CAS_LATENCY + 2);
    localparam int unsigned RC_W   = $clog2(T_RC + 1);
    localparam int unsigned REF_W  = $clog2(REFRESH_INTERVAL + 1);

    localparam logic [REF_W-1:0] REF_RELOAD = REF_W'(REFRESH_INTERVAL - 1);
    localparam logic [12:0]      MODE_WORD  = {3'b000, 1'b0, 2'b00, 3'(CAS_LATENCY), 1'b0, 3'b000};

    // {RAS_N, CAS_N, WE_N}; CS_N is held low so NOP is 3'b111
    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;

    typedef enum logic [3:0] {
        S_INIT_WAIT, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
        S_IDLE, S_REFRESH, S_ACTIVATE, S_RDWR, S_CAS_WAIT, S_RECOVER
    } state_t;

    state_t            r_state, w_state;
    logic [WAIT_W-1:0] r_wait, w_wait;
    logic [RC_W-1:0]   r_rc, w_rc;
    logic [REF_W-1:0]  r_ref_cnt, w_ref_cnt;
    logic              r_ref_pending, w_ref_pending;
    logic              w_ref_hit, w_serve_ref, w_init_done, w_in_init;
    logic              r_is_write, w_is_write;
    logic [1:0]        r_lat_ba, w_lat_ba;
    logic [8:0]        r_lat_col, w_lat_col;
    logic [15:0]       r_lat_data, w_lat_data;
    logic              r_cke;
    logic              r_cs_n;
    logic [2:0]        r_cmd, w_cmd;
    logic [1:0]        r_ba, w_ba;
    logic [12:0]       r_addr, w_addr;
    logic [1:0]        r_dqm, w_dqm;
    logic [15:0]       r_dq_out, w_dq_out;
    logic              r_dq_oe, w_dq_oe;
    logic [15:0]       r_data_out, w_data_out;
    logic              r_read_ready, w_read_ready;
    logic              w_busy;

    // Next state, timers, refresh bookkeeping and the command to register.
    always_comb begin
        w_state       = r_state;
        w_wait        = r_wait;
        w_rc          = (r_rc != '0) ? r_rc - RC_W'(1) : r_rc;
        w_ref_hit     = (r_ref_cnt == '0);
        w_ref_cnt     = w_ref_hit ? REF_RELOAD : r_ref_cnt - REF_W'(1);
        w_serve_ref   = 1'b0;
        w_init_done   = 1'b0;
        w_is_write    = r_is_write;
        w_lat_ba      = r_lat_ba;
        w_lat_col     = r_lat_col;
        w_lat_data    = r_lat_data;
        w_cmd         = CMD_NOP;
        w_ba          = '0;
        w_addr        = '0;
        w_dq_out      = '0;
        w_dq_oe       = 1'b0;
        w_data_out    = r_data_out;
        w_read_ready  = 1'b0;

        case (r_state)
            S_INIT_WAIT: begin
                if (r_wait == '0) begin
                    w_state = S_INIT_PRE;
                    w_cmd   = CMD_PRE;
                    w_addr  = 13'h0400;
                    w_wait  = WAIT_W'(T_RP - 1);
                end else begin
                    w_wait = r_wait - WAIT_W'(1);
                end
            end
            S_INIT_PRE: begin
                if (r_wait == '0) begin
                    w_state = S_INIT_REF1;
                    w_cmd   = CMD_REF;
                    w_wait  = WAIT_W'(T_RC - 1);
                end else begin
                    w_wait = r_wait - WAIT_W'(1);
                end
            end
            S_INIT_REF1: begin
                if (r_wait == '0) begin
                    w_state = S_INIT_REF2;
                    w_cmd   = CMD_REF;
                    w_wait  = WAIT_W'(T_RC - 1);
                end else begin
                    w_wait = r_wait - WAIT_W'(1);
                end
            end
            S_INIT_REF2: begin
                if (r_wait == '0) begin
                    w_state = S_INIT_MRS;
                    w_cmd   = CMD_MRS;
                    w_addr  = MODE_WORD;
                    w_wait  = WAIT_W'(1);
                end else begin
                    w_wait = r_wait - WAIT_W'(1);
                end
            end
            S_INIT_MRS: begin
                if (r_wait == '0) begin
                    w_state     = S_IDLE;
                    w_init_done = 1'b1;
                end else begin
                    w_wait = r_wait - WAIT_W'(1);
                end
            end
            S_IDLE: begin
                if (r_ref_pending) begin
                    w_state     = S_REFRESH;
                    w_cmd       = CMD_REF;
                    w_rc        = RC_W'(T_RC - 1);
                    w_serve_ref = 1'b1;
                end else if (bus.write || bus.read) begin
                    w_state    = S_ACTIVATE;
                    w_cmd      = CMD_ACT;
                    w_ba       = bus.address[23:22];
                    w_addr     = bus.address[21:9];
                    w_rc       = RC_W'(T_RC - 1);
                    w_wait     = WAIT_W'(T_RCD - 1);
                    w_is_write = bus.write;
                    w_lat_ba   = bus.address[23:22];
                    w_lat_col  = bus.address[8:0];
                    w_lat_data = bus.dataIn;
                end
            end
            S_REFRESH: begin
                w_state = S_RECOVER;
                w_wait  = WAIT_W'(T_RP - 1);
            end
            S_ACTIVATE: begin
                if (r_wait == '0) begin
                    w_state  = S_RDWR;
                    w_cmd    = r_is_write ? CMD_WR : CMD_RD;
                    w_ba     = r_lat_ba;
                    w_addr   = {2'b00, 1'b1, 1'b0, r_lat_col};
                    w_dq_oe  = r_is_write;
                    w_dq_out = r_is_write ? r_lat_data : 16'h0000;
                end else begin
                    w_wait = r_wait - WAIT_W'(1);
                end
            end
            S_RDWR: begin
                if (r_is_write) begin
                    w_state = S_RECOVER;
                    w_wait  = WAIT_W'(T_RP - 1);
                end else begin
                    w_state = S_CAS_WAIT;
                    w_wait  = WAIT_W'(CAS_LATENCY);
                end
            end
            S_CAS_WAIT: begin
                if (r_wait == '0) begin
                    w_state      = S_RECOVER;
                    w_wait       = WAIT_W'(T_RP - 1);
                    w_data_out   = bus.sdramDqIn;
                    w_read_ready = 1'b1;
                end else begin
                    w_wait = r_wait - WAIT_W'(1);
                end
            end
            S_RECOVER: begin
                if (r_wait != '0) begin
                    w_wait = r_wait - WAIT_W'(1);
                end else if (r_rc == '0) begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_INIT_WAIT;
        endcase

        w_in_init = (w_state == S_INIT_WAIT) || (w_state == S_INIT_PRE) ||
                    (w_state == S_INIT_REF1) || (w_state == S_INIT_REF2) ||
                    (w_state == S_INIT_MRS);
        w_dqm     = w_in_init ? 2'b11 : 2'b00;

        // A fresh interval expiring wins over serving the old one; init clears everything.
        if (w_init_done) begin
            w_ref_pending = 1'b0;
        end else begin
            w_ref_pending = w_ref_hit | (r_ref_pending & ~w_serve_ref);
        end
    end

    // State, timers and all registered outputs.
    always_ff @(posedge memClk or posedge reset) begin
        if (reset) begin
            r_state       <= S_INIT_WAIT;
            r_wait        <= WAIT_W'(T_INIT - 1);
            r_rc          <= '0;
            r_ref_cnt     <= REF_RELOAD;
            r_ref_pending <= 1'b0;
            r_is_write    <= 1'b0;
            r_lat_ba      <= '0;
            r_lat_col     <= '0;
            r_lat_data    <= '0;
            r_cke         <= 1'b0;
            r_cs_n        <= 1'b0;
            r_cmd         <= CMD_NOP;
            r_ba          <= '0;
            r_addr        <= '0;
            r_dqm         <= 2'b11;
            r_dq_out      <= '0;
            r_dq_oe       <= 1'b0;
            r_data_out    <= '0;
            r_read_ready  <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_wait        <= w_wait;
            r_rc          <= w_rc;
            r_ref_cnt     <= w_ref_cnt;
            r_ref_pending <= w_ref_pending;
            r_is_write    <= w_is_write;
            r_lat_ba      <= w_lat_ba;
            r_lat_col     <= w_lat_col;
            r_lat_data    <= w_lat_data;
            r_cke         <= 1'b1;
            r_cs_n        <= 1'b0;
            r_cmd         <= w_cmd;
            r_ba          <= w_ba;
            r_addr        <= w_addr;
            r_dqm         <= w_dqm;
            r_dq_out      <= w_dq_out;
            r_dq_oe       <= w_dq_oe;
            r_data_out    <= w_data_out;
            r_read_ready  <= w_read_ready;
        end
    end

    // busy reflects live strobes so a host never sees an accepted-looking idle cycle.
    assign w_busy = (r_state != S_IDLE) | r_ref_pending | bus.read | bus.write;

    assign bus.busy       = w_busy;
    assign bus.dataOut    = r_data_out;
    assign bus.readReady  = r_read_ready;
    assign bus.sdramCke   = r_cke;
    assign bus.sdramCsN   = r_cs_n;
    assign bus.sdramRasN  = r_cmd[2];
    assign bus.sdramCasN  = r_cmd[1];
    assign bus.sdramWeN   = r_cmd[0];
    assign bus.sdramBa    = r_ba;
    assign bus.sdramAddr  = r_addr;
    assign bus.sdramDqm   = r_dqm;
    assign bus.sdramDqOut = r_dq_out;
    assign bus.sdramDqOe  = r_dq_oe;
endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: init order, write, read latency,
// read+write collision, refresh priority and reset mid-read.
module tb_sdram_responder;
    localparam int unsigned T_INIT = 16;
    localparam int unsigned T_RCD  = 2;
    localparam int unsigned T_RP   = 2;
    localparam int unsigned T_RC   = 7;
    localparam int unsigned CL     = 2;
    localparam int unsigned RI     = 100;

    // {CS_N, RAS_N, CAS_N, WE_N}
    localparam logic [3:0] C_NOP = 4'b0111;
    localparam logic [3:0] C_ACT = 4'b0011;
    localparam logic [3:0] C_RD  = 4'b0101;
    localparam logic [3:0] C_WR  = 4'b0100;
    localparam logic [3:0] C_PRE = 4'b0010;
    localparam logic [3:0] C_REF = 4'b0001;
    localparam logic [3:0] C_MRS = 4'b0000;

    logic memClk = 1'b0;
    logic reset  = 1'b1;
    int   n_cmp  = 0;
    int   n_err  = 0;

    sdram_responder_if bus();

    sdram_responder #(
        .T_INIT(T_INIT), .T_RCD(T_RCD), .T_RP(T_RP), .T_RC(T_RC),
        .CAS_LATENCY(CL), .REFRESH_INTERVAL(RI)
    ) dut (
        .memClk (memClk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 memClk = ~memClk;

    function automatic logic [3:0] cmd_now();
        return {bus.sdramCsN, bus.sdramRasN, bus.sdramCasN, bus.sdramWeN};
    endfunction

    // One-word memory model: remembers last write, returns it after CAS latency.
    logic [15:0] mem_q   = 16'h0000;
    logic [7:0]  rd_pipe = 8'h00;
    always @(negedge memClk) begin
        rd_pipe = {rd_pipe[6:0], (cmd_now() == C_RD)};
        if (cmd_now() == C_WR && bus.sdramDqOe) mem_q = bus.sdramDqOut;
        bus.sdramDqIn = rd_pipe[CL+1] ? mem_q : 16'h0000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge memClk);
    endtask

    task automatic check_reset_vals(input string pfx);
        chk({pfx, "_ctrl"}, 32'({bus.sdramCke, cmd_now()}), 32'({1'b0, C_NOP}));
        chk({pfx, "_ba_addr"}, 32'({bus.sdramBa, bus.sdramAddr}), 32'd0);
        chk({pfx, "_dqm"}, 32'(bus.sdramDqm), 32'h3);
        chk({pfx, "_dq"}, 32'({bus.sdramDqOe, bus.sdramDqOut}), 32'd0);
        chk({pfx, "_busy"}, 32'(bus.busy), 32'd1);
        chk({pfx, "_rdy_data"}, 32'({bus.readReady, bus.dataOut}), 32'd0);
    endtask

    // Called right after reset release at a falling edge.
    task automatic check_init(input string pfx);
        int          ev_cyc[4];
        logic [3:0]  ev_cmd[4];
        logic [12:0] ev_addr[4];
        int          n_ev     = 0;
        int          idle_cyc = -1;
        logic        rr_seen  = 1'b0;
        for (int j = 0; j < 4; j++) begin
            ev_cyc[j] = 0; ev_cmd[j] = C_NOP; ev_addr[j] = '0;
        end
        for (int i = 1; i <= 200 && idle_cyc < 0; i++) begin
            step();
            if (i == 1) chk({pfx, "_cke"}, 32'(bus.sdramCke), 32'd1);
            if (bus.readReady) rr_seen = 1'b1;
            if (cmd_now() != C_NOP) begin
                if (n_ev < 4) begin
                    ev_cyc[n_ev]  = i;
                    ev_cmd[n_ev]  = cmd_now();
                    ev_addr[n_ev] = bus.sdramAddr;
                end
                n_ev++;
            end
            if (bus.busy === 1'b0) idle_cyc = i;
        end
        chk({pfx, "_ncmds"}, 32'(n_ev), 32'd4);
        chk({pfx, "_pre"}, 32'({ev_cmd[0], ev_addr[0][10], 8'(ev_cyc[0])}), 32'({C_PRE, 1'b1, 8'd16}));
        chk({pfx, "_ref1"}, 32'({ev_cmd[1], 8'(ev_cyc[1])}), 32'({C_REF, 8'd18}));
        chk({pfx, "_ref2"}, 32'({ev_cmd[2], 8'(ev_cyc[2])}), 32'({C_REF, 8'd25}));
        chk({pfx, "_mrs"}, 32'({ev_cmd[3], ev_addr[3], 8'(ev_cyc[3])}), 32'({C_MRS, 13'h020, 8'd32}));
        chk({pfx, "_busy_fall"}, 32'(idle_cyc), 32'd34);
        chk({pfx, "_no_rdy"}, 32'(rr_seen), 32'd0);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (bus.busy !== 1'b0 && k < 400) begin
            step();
            k++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    // Returns at the falling edge just after the acceptance edge (k = 0).
    task automatic issue(input logic wr, input logic rd, input logic [23:0] a, input logic [15:0] d);
        wait_idle();
        bus.address = a;
        bus.dataIn  = d;
        bus.write   = wr;
        bus.read    = rd;
        step();
        bus.write   = 1'b0;
        bus.read    = 1'b0;
    endtask

    initial begin
        logic flag_a;
        logic flag_b;
        logic flag_c;
        int   got;

        bus.address = '0;
        bus.write   = 1'b0;
        bus.read    = 1'b0;
        bus.dataIn  = '0;
        reset       = 1'b1;
        repeat (3) step();
        check_reset_vals("rst0");
        reset = 1'b0;
        check_init("init0");

        // Write bank 1, row 1, column 3
        issue(1'b1, 1'b0, 24'h400203, 16'hBEEF);
        chk("wr_act_cmd", 32'(cmd_now()), 32'(C_ACT));
        chk("wr_act_ba_row", 32'({bus.sdramBa, bus.sdramAddr}), 32'({2'd1, 13'd1}));
        step();
        chk("wr_gap_nop", 32'(cmd_now()), 32'(C_NOP));
        step();
        chk("wr_cmd", 32'(cmd_now()), 32'(C_WR));
        chk("wr_ba_col", 32'({bus.sdramBa, bus.sdramAddr}), 32'({2'd1, 13'h403}));
        chk("wr_dq", 32'({bus.sdramDqOe, bus.sdramDqm, bus.sdramDqOut}), 32'({1'b1, 2'b00, 16'hBEEF}));
        step();
        chk("wr_oe_one_cycle", 32'(bus.sdramDqOe), 32'd0);

        // Read back: readReady exactly 6 cycles after acceptance
        issue(1'b0, 1'b1, 24'h400203, 16'h0000);
        chk("rd_act_cmd", 32'(cmd_now()), 32'(C_ACT));
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 2) chk("rd_cmd", 32'({cmd_now(), bus.sdramBa, bus.sdramAddr}), 32'({C_RD, 2'd1, 13'h403}));
            chk($sformatf("rd_ready_k%0d", k), 32'(bus.readReady), (k == 6) ? 32'd1 : 32'd0);
            if (k == 6) chk("rd_data", 32'(bus.dataOut), 32'hBEEF);
        end

        // Read and write together: write wins, no readReady, dataOut holds
        issue(1'b1, 1'b1, 24'h000005, 16'h1234);
        chk("rw_act_cmd", 32'(cmd_now()), 32'(C_ACT));
        flag_a = 1'b0; flag_b = 1'b0; flag_c = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (cmd_now() == C_WR) flag_a = 1'b1;
            if (cmd_now() == C_RD) flag_b = 1'b1;
            if (bus.readReady)     flag_c = 1'b1;
        end
        chk("rw_write_seen", 32'(flag_a), 32'd1);
        chk("rw_no_read_cmd", 32'(flag_b), 32'd0);
        chk("rw_no_ready", 32'(flag_c), 32'd0);
        chk("rw_data_hold", 32'(bus.dataOut), 32'hBEEF);

        // Refresh pending collides with a request in IDLE
        wait_idle();
        got = 0;
        for (int i = 0; i < 300 && got == 0; i++) begin
            step();
            if (bus.busy === 1'b1) got = 1;
        end
        chk("ref_pending_seen", 32'(got), 32'd1);
        bus.address = 24'h000010;
        bus.dataIn  = 16'h5555;
        bus.write   = 1'b1;
        step();
        bus.write   = 1'b0;
        chk("ref_cmd", 32'(cmd_now()), 32'(C_REF));
        chk("ref_busy_k0", 32'(bus.busy), 32'd1);
        flag_a = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            if (cmd_now() == C_ACT) flag_a = 1'b1;
            chk($sformatf("ref_busy_k%0d", k), 32'(bus.busy), (k < 7) ? 32'd1 : 32'd0);
        end
        chk("ref_req_ignored", 32'(flag_a), 32'd0);
        issue(1'b1, 1'b0, 24'h000010, 16'h5555);
        chk("ref_reissue_act", 32'({cmd_now(), bus.sdramBa, bus.sdramAddr}), 32'({C_ACT, 2'd0, 13'd0}));

        // Reset between READ and data return
        issue(1'b0, 1'b1, 24'h400203, 16'h0000);
        step();
        step();
        chk("rst_mid_rd_cmd", 32'(cmd_now()), 32'(C_RD));
        step();
        reset = 1'b1;
        step();
        check_reset_vals("rst_mid");
        flag_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (bus.readReady) flag_a = 1'b1;
        end
        chk("rst_mid_no_ready", 32'(flag_a), 32'd0);
        reset = 1'b0;
        check_init("init1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
